// File: rtl/otl_mem_arbiter_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// otl_mem_arbiter_if
//
// Bundles every handshake and bus signal of otl_mem_arbiter:
//   - write request channel  : wr_valid, wr_ready, wr_addr, wr_data, wr_strb
//   - read request channel   : rd_valid, rd_ready, rd_addr
//   - read response channel  : rd_resp_valid, rd_resp_ready, rd_resp_data
//   - single-port RAM port   : mem_en, mem_we, mem_addr, mem_wdata, mem_be,
//                              mem_rdata
//
// Modports:
//   slave  - the arbiter itself (accepts requests, drives the RAM port)
//   master - the surroundings: the requesters and the RAM behind the arbiter
//
// Parameters:
//   ADDRW - request byte-address width
//   DATAW - data width, a multiple of 8
//   MEMAW - RAM word-address width
// ---------------------------------------------------------------------------
interface otl_mem_arbiter_if #(
   parameter int ADDRW = 32,
   parameter int DATAW = 32,
   parameter int MEMAW = 10
);

   // write request channel
   logic                 wr_valid;
   logic                 wr_ready;
   logic [ADDRW-1:0]     wr_addr;
   logic [DATAW-1:0]     wr_data;
   logic [DATAW/8-1:0]   wr_strb;

   // read request channel
   logic                 rd_valid;
   logic                 rd_ready;
   logic [ADDRW-1:0]     rd_addr;

   // read response channel
   logic                 rd_resp_valid;
   logic                 rd_resp_ready;
   logic [DATAW-1:0]     rd_resp_data;

   // RAM port
   logic                 mem_en;
   logic                 mem_we;
   logic [MEMAW-1:0]     mem_addr;
   logic [DATAW-1:0]     mem_wdata;
   logic [DATAW/8-1:0]   mem_be;
   logic [DATAW-1:0]     mem_rdata;

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_strb,
      input  rd_valid, rd_addr,
      input  rd_resp_ready,
      input  mem_rdata,
      output wr_ready, rd_ready,
      output rd_resp_valid, rd_resp_data,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output wr_valid, wr_addr, wr_data, wr_strb,
      output rd_valid, rd_addr,
      output rd_resp_ready,
      output mem_rdata,
      input  wr_ready, rd_ready,
      input  rd_resp_valid, rd_resp_data,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
   );

endinterface

// File: rtl/otl_mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// otl_mem_arbiter
//
// Serialises independent write and read requests from the OTL AXI-lite slave
// onto one synchronous single-port RAM (read latency 1), one access at a
// time, and holds each read result until the requester takes it.
//
// Ports:
//   s_axi_aclk     in   clock, everything on the rising edge
//   s_axi_aresetn  in   asynchronous active-low reset
//   bus            slave modport of otl_mem_arbiter_if:
//                    wr_valid/wr_ready/wr_addr/wr_data/wr_strb  write request
//                    rd_valid/rd_ready/rd_addr                  read request
//                    rd_resp_valid/rd_resp_ready/rd_resp_data   read response
//                    mem_en/mem_we/mem_addr/mem_wdata/mem_be    RAM command
//                    mem_rdata                                  RAM read data
//
// Parameters:
//   ADDRW (32) byte-address width, DATAW (32) data width, MEMAW (10) RAM
//   word-address width. mem_addr is the word index taken from the byte
//   address; bits above and below that range are ignored silently.
//
// Configuration macro:
//   OTL_MEM_ARB_WPRIO_EN  when defined, a write always wins a simultaneous
//                         request (reads may starve). When undefined, ties
//                         alternate round-robin via last_grant.
//
// Sequencing (E0 = accepting edge):
//   write : mem_en high E0..E1, idle again at E1, next accept at E2
//   read  : mem_en high E0..E1, RAM data captured at E2, rd_resp_valid from
//           E2 until rd_resp_ready; no request is accepted meanwhile
// ---------------------------------------------------------------------------
module otl_mem_arbiter #(
   parameter int ADDRW = 32,
   parameter int DATAW = 32,
   parameter int MEMAW = 10
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   otl_mem_arbiter_if.slave  bus
);

   localparam int BYTEW = DATAW / 8;
   localparam int OFFW  = $clog2(BYTEW);

`ifdef OTL_MEM_ARB_WPRIO_EN
   localparam bit WPRIO_EN = 1'b1;
`else
   localparam bit WPRIO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      RDLAT,
      RESP
   } state_t;

   typedef enum logic {
      GNT_WRITE,
      GNT_READ
   } grant_t;

   state_t             state;
   grant_t             last_grant;

   logic               mem_en_q;
   logic               mem_we_q;
   logic [MEMAW-1:0]   mem_addr_q;
   logic [DATAW-1:0]   mem_wdata_q;
   logic [BYTEW-1:0]   mem_be_q;
   logic               rd_resp_valid_q;
   logic [DATAW-1:0]   rd_resp_data_q;

   logic               write_wins_tie;
   logic               grant_wr;
   logic               grant_rd;

   logic [MEMAW-1:0]   wr_word;
   logic [MEMAW-1:0]   rd_word;

   // Only the word-index bits of the byte addresses reach the RAM; the rest
   // are folded here so they are visibly consumed.
   logic               unused_addr_bits;

   assign wr_word          = bus.wr_addr[MEMAW+OFFW-1:OFFW];
   assign rd_word          = bus.rd_addr[MEMAW+OFFW-1:OFFW];
   assign unused_addr_bits = ^{bus.wr_addr, bus.rd_addr};

   // -----------------------------------------------------------------------
   // Grant decision. Ready is combinational and only ever offered in IDLE,
   // and is held low while reset is asserted so both readies read 0 then.
   // -----------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      write_wins_tie = 1'b0;
      grant_wr       = 1'b0;
      grant_rd       = 1'b0;

      // With write priority the round-robin pointer is kept but overruled.
      write_wins_tie = WPRIO_EN || (last_grant == GNT_READ);

      if (s_axi_aresetn && (state == IDLE)) begin
         grant_wr = bus.wr_valid && (!bus.rd_valid || write_wins_tie);
         grant_rd = bus.rd_valid && !grant_wr;
      end
   end

   assign bus.wr_ready = grant_wr;
   assign bus.rd_ready = grant_rd;

   // -----------------------------------------------------------------------
   // Sequencer: one FSM, all outputs registered.
   // -----------------------------------------------------------------------
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state           <= IDLE;
         last_grant      <= GNT_READ;
         mem_en_q        <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         mem_be_q        <= '0;
         rd_resp_valid_q <= 1'b0;
         rd_resp_data_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, whatever the statement order.
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  state       <= WR;
                  last_grant  <= GNT_WRITE;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= wr_word;
                  mem_wdata_q <= bus.wr_data;
                  mem_be_q    <= bus.wr_strb;
               end else if (grant_rd) begin
                  // Write data and strobes keep their previous values.
                  state      <= RD;
                  last_grant <= GNT_READ;
                  mem_en_q   <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= rd_word;
               end
            end

            WR: begin
               mem_en_q <= 1'b0;
               state    <= IDLE;
            end

            RD: begin
               mem_en_q <= 1'b0;
               state    <= RDLAT;
            end

            // The RAM presents the word during this cycle (latency 1).
            RDLAT: begin
               rd_resp_data_q  <= bus.mem_rdata;
               rd_resp_valid_q <= 1'b1;
               state           <= RESP;
            end

            // Response data stays put until it is taken; requests wait.
            RESP: begin
               if (bus.rd_resp_ready) begin
                  rd_resp_valid_q <= 1'b0;
                  state           <= IDLE;
               end
            end

            default: begin
               mem_en_q        <= 1'b0;
               rd_resp_valid_q <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_en        = mem_en_q;
   assign bus.mem_we        = mem_we_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;
   assign bus.mem_be        = mem_be_q;
   assign bus.rd_resp_valid = rd_resp_valid_q;
   assign bus.rd_resp_data  = rd_resp_data_q;

endmodule

// File: doc/otl_mem_arbiter.md
# otl_mem_arbiter

Single-port memory arbiter placed between the OTL AXI-lite slave's write and read request paths and one synchronous single-port RAM. It accepts independent write and read requests over valid/ready handshakes and serialises them onto the RAM port, one access at a time. It holds each read result until the requester accepts it. Tie-breaking is round-robin, or fixed write priority when configured.

## Interface
- ADDRW, 32: byte address width of requests.
- DATAW, 32: data width; multiple of 8.
- MEMAW, 10: RAM word-address width; mem_addr = req_addr[MEMAW+log2(DATAW/8)-1 : log2(DATAW/8)].

- s_axi_aclk  in  1  clock; all logic on rising edge.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted this cycle.
- wr_addr  in  ADDRW  write byte address.
- wr_data  in  DATAW  write data.
- wr_strb  in  DATAW/8  byte enables.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_addr  in  ADDRW  read byte address.
- rd_resp_valid  out  1  read data available.
- rd_resp_ready  in  1  read data consumed.
- rd_resp_data  out  DATAW  read data.
- mem_en  out  1  RAM access strobe, one cycle per access.
- mem_we  out  1  1 = write, 0 = read; valid with mem_en.
- mem_addr  out  MEMAW  RAM word address.
- mem_wdata  out  DATAW  RAM write data.
- mem_be  out  DATAW/8  RAM byte enables.
- mem_rdata  in  DATAW  RAM read data; valid the cycle after the mem_en read cycle (fixed latency 1).

## Operation
- FSM states: IDLE, WR, RD, RDLAT, RESP. Reset state is IDLE.
- wr_ready and rd_ready are combinational. Both are 0 outside IDLE, and at most one is 1 in any cycle.
- IDLE, only wr_valid: wr_ready = 1; go to WR.
- IDLE, only rd_valid: rd_ready = 1; go to RD.
- IDLE, both valid: grant goes to the requester not in last_grant; last_grant updates on every grant.
- last_grant resets to READ, so the first tie goes to the write.
- On accept, the address, data and strobe are registered into the mem_* output registers.
- WR: mem_en = 1, mem_we = 1 for exactly one cycle, then IDLE.
- RD: mem_en = 1, mem_we = 0 for one cycle, then RDLAT.
- RDLAT: mem_en = 0. mem_rdata is captured into rd_resp_data at the end of the cycle; go to RESP.
- RESP: rd_resp_valid = 1 and rd_resp_data held stable until rd_resp_ready = 1, then IDLE. No new request is accepted while in RESP.
- mem_wdata, mem_be, mem_addr and mem_we keep their last values when mem_en = 0.
- Address bits above the word range and below the word offset are ignored; no range error is flagged.
- Reset asserted mid-operation: immediate return to IDLE; all outputs go to reset values; the in-flight access is dropped and no response is produced.

## Timing
- Reset values: wr_ready = 0, rd_ready = 0, rd_resp_valid = 0, rd_resp_data = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0, last_grant = READ.
- Write: accepted at edge E0; mem_en high during E0..E1; next accept possible at E2. Throughput: 1 write per 2 cycles.
- Read: accepted at E0; mem_en during E0..E1; rdata captured at E2; rd_resp_valid high from E2. With rd_resp_ready held at 1, IDLE at E3 and next accept at E4.
- rd_resp_ready held at 0 stalls the FSM in RESP indefinitely; write requests also wait.
- wr_valid/rd_valid may deassert without acceptance; no requirement is placed on requesters to hold them.

## Configuration
- OTL_MEM_ARB_WPRIO_EN defined: a write always wins a simultaneous request. last_grant is still maintained but ignored. Reads may starve under continuous writes.
- OTL_MEM_ARB_WPRIO_EN undefined (default): round-robin tie-break as described above.

## Test plan
- Single write, addr 0x10, data 0xDEADBEEF, strb 0xF -> one mem_en cycle with mem_we = 1, mem_addr = 4, mem_be = 0xF; wr_ready high exactly one cycle.
- Read of addr 0x10 after that write; RAM model returns 0xDEADBEEF -> rd_resp_valid rises 2 cycles after accept with data 0xDEADBEEF.
- wr_valid and rd_valid both held high for 8 grants (default build) -> grants W, R, W, R, …; no two consecutive grants to the same requester.
- Same stimulus with OTL_MEM_ARB_WPRIO_EN -> all grants go to write while wr_valid is high; the read is granted only after wr_valid drops.
- rd_resp_ready held at 0 for 10 cycles with a write pending -> rd_resp_valid and rd_resp_data stable; wr_ready stays 0; the write is granted in the cycle after the response handshake (IDLE).
- s_axi_aresetn pulsed low during RDLAT -> all outputs 0 immediately; no rd_resp_valid after release; next tie is granted to write.
